// File: rtl/frog_input_conditioner.sv
// Synchronises, debounces and arbitrates the four frog direction switches into one clean level.
// Optional auto-repeat gaps while a direction is held: define FROG_AUTO_REPEAT_EN.
module frog_input_conditioner #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 5000000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch_Up,
    input  logic i_Switch_Dn,
    input  logic i_Switch_Lt,
    input  logic i_Switch_Rt,
    output logic o_Frog_Up,
    output logic o_Frog_Dn,
    output logic o_Frog_Lt,
    output logic o_Frog_Rt,
    output logic o_Lockout
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    // Bit order throughout: 0 = up, 1 = down, 2 = left, 3 = right.
    logic [3:0]       switch_raw_s;
    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       stable_r;
    logic [CNT_W-1:0] db_cnt_r [4];

    state_t     state_r;
    logic [3:0] dir_r;
    logic [3:0] frog_r;
    logic       lockout_r;

    logic [2:0] n_high_s;
    logic       own_held_s;
    logic       other_held_s;

    function automatic logic [2:0] count_ones(input logic [3:0] v);
        count_ones = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    assign switch_raw_s = {i_Switch_Rt, i_Switch_Lt, i_Switch_Dn, i_Switch_Up};

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= switch_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-switch debounce: stable value flips after DEBOUNCE_LIMIT consecutive mismatches
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            stable_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == CNT_MAX) begin
                    stable_r[i] <= sync2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
                end
            end
        end
    end

    // Arbitration decode of the debounced switch set against the held direction
    always_comb begin
        n_high_s     = count_ones(stable_r);
        own_held_s   = 1'b0;
        other_held_s = 1'b0;
        if (state_r == ST_ACTIVE) begin
            own_held_s   = |(stable_r & dir_r);
            other_held_s = |(stable_r & ~dir_r);
        end else begin
            own_held_s   = 1'b0;
            other_held_s = 1'b0;
        end
    end

`ifdef FROG_AUTO_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_inc_s;
    logic              repeating_r;

    assign hold_inc_s = hold_cnt_r + 1'b1;
`else
    logic cfg_unused_s;
    assign cfg_unused_s = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

    // Arbitration FSM with registered direction and lockout outputs
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r     <= ST_IDLE;
            dir_r       <= 4'b0000;
            frog_r      <= 4'b0000;
            lockout_r   <= 1'b0;
`ifdef FROG_AUTO_REPEAT_EN
            hold_cnt_r  <= '0;
            repeating_r <= 1'b0;
`endif
        end else begin
`ifdef FROG_AUTO_REPEAT_EN
            hold_cnt_r  <= '0;
            repeating_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (n_high_s == 3'd1) begin
                        state_r   <= ST_ACTIVE;
                        dir_r     <= stable_r;
                        frog_r    <= stable_r;
                        lockout_r <= 1'b0;
                    end else if (n_high_s >= 3'd2) begin
                        state_r   <= ST_LOCKOUT;
                        dir_r     <= 4'b0000;
                        frog_r    <= 4'b0000;
                        lockout_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        dir_r     <= 4'b0000;
                        frog_r    <= 4'b0000;
                        lockout_r <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    // Another press wins over a simultaneous release: conflicts always lock out
                    if (other_held_s) begin
                        state_r   <= ST_LOCKOUT;
                        dir_r     <= 4'b0000;
                        frog_r    <= 4'b0000;
                        lockout_r <= 1'b1;
                    end else if (!own_held_s) begin
                        state_r   <= ST_IDLE;
                        dir_r     <= 4'b0000;
                        frog_r    <= 4'b0000;
                        lockout_r <= 1'b0;
                    end else begin
                        state_r   <= ST_ACTIVE;
                        dir_r     <= dir_r;
                        lockout_r <= 1'b0;
`ifdef FROG_AUTO_REPEAT_EN
                        if (!repeating_r && (hold_inc_s == HOLD_DELAY)) begin
                            frog_r      <= 4'b0000;
                            hold_cnt_r  <= '0;
                            repeating_r <= 1'b1;
                        end else if (repeating_r && (hold_inc_s == HOLD_PERIOD)) begin
                            frog_r      <= 4'b0000;
                            hold_cnt_r  <= '0;
                            repeating_r <= 1'b1;
                        end else begin
                            frog_r      <= dir_r;
                            hold_cnt_r  <= hold_inc_s;
                            repeating_r <= repeating_r;
                        end
`else
                        frog_r    <= dir_r;
`endif
                    end
                end
                ST_LOCKOUT: begin
                    frog_r <= 4'b0000;
                    dir_r  <= 4'b0000;
                    if (stable_r == 4'b0000) begin
                        state_r   <= ST_IDLE;
                        lockout_r <= 1'b0;
                    end else begin
                        state_r   <= ST_LOCKOUT;
                        lockout_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    dir_r     <= 4'b0000;
                    frog_r    <= 4'b0000;
                    lockout_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_Frog_Up = frog_r[0];
    assign o_Frog_Dn = frog_r[1];
    assign o_Frog_Lt = frog_r[2];
    assign o_Frog_Rt = frog_r[3];
    assign o_Lockout = lockout_r;

endmodule

// File: tb/tb_frog_input_conditioner.sv
// Directed and randomized bench for frog_input_conditioner against a history-based reference model.
module tb_frog_input_conditioner;

    localparam int L      = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 5;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    logic sw_up = 1'b0, sw_dn = 1'b0, sw_lt = 1'b0, sw_rt = 1'b0;
    logic o_up, o_dn, o_lt, o_rt, o_lock;
    logic [3:0] frog;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: window of raw samples, debounced levels, held direction.
    logic [3:0] hist[$];
    logic [3:0] m_stable;
    int         m_dir;   // -1 none, 0..3 direction held, 4 conflict lockout
    int         m_hold;
    logic [3:0] exp_frog;
    logic       exp_lock;

    frog_input_conditioner #(
        .DEBOUNCE_LIMIT(L),
        .REPEAT_DELAY(DELAY),
        .REPEAT_PERIOD(PERIOD)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .i_Switch_Up(sw_up),
        .i_Switch_Dn(sw_dn),
        .i_Switch_Lt(sw_lt),
        .i_Switch_Rt(sw_rt),
        .o_Frog_Up(o_up),
        .o_Frog_Dn(o_dn),
        .o_Frog_Lt(o_lt),
        .o_Frog_Rt(o_rt),
        .o_Lockout(o_lock)
    );

    assign frog = {o_rt, o_lt, o_dn, o_up};

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < L + 2; i++) hist.push_back(4'b0000);
        m_stable = 4'b0000;
        m_dir    = -1;
        m_hold   = 0;
        exp_frog = 4'b0000;
        exp_lock = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] sw);
        int  n;
        bit  gap;
        bit  all_diff;
        n   = $countones(m_stable);
        gap = 0;
        if (m_dir == -1) begin
            if (n == 1) begin
                for (int b = 0; b < 4; b++) if (m_stable[b]) m_dir = b;
                m_hold = 0;
            end else if (n >= 2) begin
                m_dir = 4;
            end
        end else if (m_dir == 4) begin
            if (m_stable == 4'b0000) m_dir = -1;
        end else begin
            if ((m_stable & ~(4'b0001 << m_dir)) != 4'b0000) m_dir = 4;
            else if (!m_stable[m_dir]) m_dir = -1;
            else m_hold++;
        end
`ifdef FROG_AUTO_REPEAT_EN
        if (m_dir >= 0 && m_dir < 4 && m_hold >= DELAY && ((m_hold - DELAY) % PERIOD) == 0)
            gap = 1;
`endif
        exp_frog = (m_dir >= 0 && m_dir < 4 && !gap) ? (4'b0001 << m_dir) : 4'b0000;
        exp_lock = (m_dir == 4);
        // Stable level flips once the last L synchronised samples all disagree with it.
        hist.push_back(sw);
        for (int b = 0; b < 4; b++) begin
            all_diff = 1;
            for (int k = 1; k <= L; k++) if (hist[k][b] == m_stable[b]) all_diff = 0;
            if (all_diff) m_stable[b] = ~m_stable[b];
        end
        void'(hist.pop_front());
    endtask

    task automatic step(input logic [3:0] sw, input logic rst);
        @(negedge i_Clk);
        i_Rst = rst;
        {sw_rt, sw_lt, sw_dn, sw_up} = sw;
        @(posedge i_Clk);
        if (rst) model_reset();
        else model_edge(sw);
        #1;
        check("frog", {1'b0, frog}, {1'b0, exp_frog});
        check("lockout", {4'b0000, o_lock}, {4'b0000, exp_lock});
        check("exclusive", {4'b0000, ($countones(frog) <= 1) && !(o_lock && (frog != 4'b0000))}, 5'b00001);
    endtask

    task automatic wait_level(input logic [3:0] sw, input int idx, input logic lvl, output int k);
        k = -1;
        for (int i = 0; i < 20; i++) begin
            step(sw, 1'b0);
            if (frog[idx] === lvl) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_lock(input logic [3:0] sw, input logic lvl, output int k);
        k = -1;
        for (int i = 0; i < 20; i++) begin
            step(sw, 1'b0);
            if (o_lock === lvl) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int   k;
        int   gaps;
        int   rise;
        logic seen;
        logic [3:0] pat;
        int   dur;
        int   mode;

        model_reset();
        #1;
        check("reset_out", {o_lock, frog}, 5'b00000);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);

        // Clean press and release latency on up.
        wait_level(4'b0001, 0, 1'b1, k);
        check("up_rise_edge", 5'(k), 5'd6);
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b0);
        wait_level(4'b0000, 0, 1'b0, k);
        check("up_fall_edge", 5'(k), 5'd6);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);

        // Bouncing left never qualifies.
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(((i / 2) % 2) ? 4'b0100 : 4'b0000, 1'b0);
            seen = seen | o_lt | o_lock;
        end
        for (int i = 0; i < 8; i++) begin
            step(4'b0000, 1'b0);
            seen = seen | o_lt | o_lock;
        end
        check("bounce_quiet", {4'b0000, seen}, 5'b00000);

        // Right held, then down joins: lockout until everything released.
        wait_level(4'b1000, 3, 1'b1, k);
        check("rt_rise_edge", 5'(k), 5'd6);
        wait_lock(4'b1010, 1'b1, k);
        check("rt_dn_lock_edge", 5'(k), 5'd6);
        check("rt_dn_lock_out", {o_lock, frog}, 5'b10000);
        for (int i = 0; i < 10; i++) step(4'b1000, 1'b0);
        check("dn_released_held", {o_lock, frog}, 5'b10000);
        wait_lock(4'b0000, 1'b0, k);
        check("lock_release_edge", 5'(k), 5'd6);
        wait_level(4'b1000, 3, 1'b1, k);
        check("rt_repress_edge", 5'(k), 5'd6);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);

        // Simultaneous up and down.
        wait_lock(4'b0011, 1'b1, k);
        check("updn_lock_edge", 5'(k), 5'd6);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0011, 1'b0);
            seen = seen | (frog != 4'b0000) | ~o_lock;
        end
        check("updn_hold", {4'b0000, seen}, 5'b00000);
        wait_lock(4'b0000, 1'b0, k);
        check("updn_release_edge", 5'(k), 5'd6);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);

        // Mid-cycle reset while down is active, then re-debounce.
        wait_level(4'b0010, 1, 1'b1, k);
        check("dn_rise_edge", 5'(k), 5'd6);
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
        #2 i_Rst = 1'b1;
        #1;
        check("async_reset_out", {o_lock, frog}, 5'b00000);
        model_reset();
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b1);
        wait_level(4'b0010, 1, 1'b1, k);
        check("dn_after_reset_edge", 5'(k), 5'd6);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);

        // Long hold on up: gaps only with auto-repeat.
        rise = -1;
        gaps = 0;
        for (int i = 0; i < 40; i++) begin
            step(4'b0001, 1'b0);
            if (rise < 0 && o_up === 1'b1) rise = i;
            else if (rise >= 0 && o_up === 1'b0) gaps++;
        end
        check("hold_rise_edge", 5'(rise), 5'd6);
`ifdef FROG_AUTO_REPEAT_EN
        check("hold_gaps", 5'(gaps), 5'd5);
`else
        check("hold_gaps", 5'(gaps), 5'd0);
`endif
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);

        // Randomized segments: single presses, conflicts, idle and bounce.
        for (int s = 0; s < 120; s++) begin
            mode = $urandom_range(0, 9);
            dur  = $urandom_range(1, 12);
            if (mode < 5) pat = 4'b0001 << $urandom_range(0, 3);
            else if (mode < 7) pat = 4'($urandom_range(0, 15));
            else pat = 4'b0000;
            for (int i = 0; i < dur; i++) begin
                if (mode == 9) step(4'($urandom_range(0, 15)), 1'b0);
                else step(pat, 1'b0);
            end
        end
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b0);
        check("final_idle", {o_lock, frog}, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
